nbit_4x1_multiplexer: RTL and testbench
=======================================

// Module: nbit_4x1_multiplexer
// PURPOSE
//   Parameterised-width 4-to-1 data multiplexer with a registered output.
//   Selects one of four n-bit words A/B/C/D using a 2-bit select S.
//   The chosen word is captured on the clock edge, so Y is glitch-free.
//   Used as a generic datapath steering element wherever a registered 4-way choice is needed.
// PARAMETERS
//   n   default 4   data width in bits of A, B, C, D and Y; legal range n >= 1
// PORTS
//   clk    input   1   single system clock; all state updates on the rising edge
//   rst_n  input   1   asynchronous, active-low reset
//   A      input   n   data word selected when S = 2'b00
//   B      input   n   data word selected when S = 2'b01
//   C      input   n   data word selected when S = 2'b10
//   D      input   n   data word selected when S = 2'b11
//   S      input   2   select code
//   Y      output  n   registered selected word
// BEHAVIOUR
//   - One clock (clk). Reset is asynchronous and active-low (rst_n).
//   - Reset: when rst_n = 0, Y is forced to {n{1'b0}} immediately, with no clock required.
//     Y is held at zero for as long as rst_n stays low.
//   - Reset release: rst_n deasserting is synchronised by design intent.
//     Y is updated at the first rising clk edge that occurs while rst_n = 1.
//   - Selection function, evaluated on each rising clk edge while rst_n = 1:
//       S=00 -> Y<=A;  S=01 -> Y<=B;  S=10 -> Y<=C;  S=11 -> Y<=D.
//   - Latency: exactly 1 cycle. The value of Y after edge k reflects A..D and S
//     as sampled at edge k. Y holds its value between edges.
//   - Input changes between edges (data or S) have no effect on Y until the next edge.
//     Y never shows combinational glitches.
//   - S containing X/Z (simulation only): Y <= {n{1'bx}}.
//     Synthesis needs no special handling, because all four codes are decoded.
//   - Width rule: no extension, truncation or arithmetic. Y is a bit-exact copy
//     of the selected input, all n bits.
//   - Reset mid-operation: an asynchronous clear overrides any pending capture.
//     Normal selection resumes at the first edge after release.
//   - No enable, no handshake. Every clocked edge outside reset reloads Y.
// TESTING (bench instantiates n=8; A=8'd10, B=8'd6, C=8'd13, D=8'd1)
//   1. Hold rst_n=0 with inputs toggling -> Y=8'd0 throughout, including between edges.
//   2. Release reset, S=2'b00, one edge -> Y=8'd10 (00001010).
//      Before that edge, Y is still 0.
//   3. Step S=01, 10, 11 on successive cycles -> Y=6, 13, 1 (00000110, 00001101, 00000001).
//      Each value appears one edge after S changes.
//   4. Change A mid-cycle while S=00 -> Y is unchanged until the next rising edge,
//      then takes the new A.
//   5. Assert rst_n low between edges while Y=13 -> Y drops to 0 immediately (asynchronously).
//      After release with S=11, the next edge gives Y=1.
//   6. Width check with n=1 and n=16 (e.g. A=16'hA5A5, S=00) -> Y=16'hA5A5 after one edge.
//      All bits pass through bit-exact.

Source files
------------

// File: rtl/nbit_4x1_multiplexer.sv
// Parameterised-width 4-to-1 multiplexer with a registered, glitch-free output.
// The selected word is captured on each rising edge outside reset.
module nbit_4x1_multiplexer #(
    parameter int unsigned n = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic [n-1:0] C,
    input  logic [n-1:0] D,
    input  logic [1:0]   S,
    output logic [n-1:0] Y
);

    logic [n-1:0] y_d;
    logic [n-1:0] y_q;

    // Select decode; an unknown select propagates X in simulation only.
    always_comb begin
        y_d = y_q;
        case (S)
            2'b00:   y_d = A;
            2'b01:   y_d = B;
            2'b10:   y_d = C;
            2'b11:   y_d = D;
            default: y_d = {n{1'bx}};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign Y = y_q;

endmodule

// File: tb/tb_nbit_4x1_multiplexer.sv
// Scoreboard bench for nbit_4x1_multiplexer at widths 8, 16 and 1 sharing clock, reset and select.
module tb_nbit_4x1_multiplexer;

    typedef struct packed {
        logic [7:0]  y8;
        logic [15:0] y16;
        logic        y1;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  S;
    logic [7:0]  a8, b8, c8, d8;
    logic [15:0] a16, b16, c16, d16;
    logic        a1, b1, c1, d1;
    logic [7:0]  Y8;
    logic [15:0] Y16;
    logic        Y1;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    exp_t last;

    nbit_4x1_multiplexer #(.n(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .C(c8), .D(d8), .S(S), .Y(Y8)
    );
    nbit_4x1_multiplexer #(.n(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .C(c16), .D(d16), .S(S), .Y(Y16)
    );
    nbit_4x1_multiplexer #(.n(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .C(c1), .D(d1), .S(S), .Y(Y1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] pick(input logic [1:0] s, input logic [15:0] a,
                                         input logic [15:0] b, input logic [15:0] c,
                                         input logic [15:0] d);
        logic [15:0] w [4];
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        return w[s];
    endfunction

    // Drive one cycle at the falling edge, check hold before the rising edge, then score.
    task automatic step(input logic r, input logic [1:0] s);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        S     = s;
        if (!r) last = '0;
        #1;
        check("hold8", 16'(Y8), 16'(last.y8));
        check("hold16", Y16, last.y16);
        e.y8  = r ? 8'(pick(s, 16'(a8), 16'(b8), 16'(c8), 16'(d8))) : 8'd0;
        e.y16 = r ? pick(s, a16, b16, c16, d16) : 16'd0;
        e.y1  = r ? 1'(pick(s, 16'(a1), 16'(b1), 16'(c1), 16'(d1))) : 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        last = sb.pop_front();
        check("y8", 16'(Y8), 16'(last.y8));
        check("y16", Y16, last.y16);
        check("y1", 16'(Y1), 16'(last.y1));
    endtask

    task automatic set_ref();
        a8 = 8'd10; b8 = 8'd6; c8 = 8'd13; d8 = 8'd1;
        a16 = 16'hA5A5; b16 = 16'h5A5A; c16 = 16'hFFFF; d16 = 16'h0001;
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b1; d1 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        S     = 2'b00;
        last  = '0;
        set_ref();
        #2;
        check("rst8", 16'(Y8), 16'd0);

        // Reset held with toggling inputs
        for (int i = 0; i < 4; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom); d8 = 8'($urandom);
            a16 = 16'($urandom); d16 = 16'($urandom);
            step(1'b0, 2'($urandom));
        end
        set_ref();

        // Release and walk the select codes
        step(1'b1, 2'b00);
        check("walkA", 16'(Y8), 16'd10);
        check("wideA", Y16, 16'hA5A5);
        step(1'b1, 2'b01);
        check("walkB", 16'(Y8), 16'd6);
        step(1'b1, 2'b10);
        check("walkC", 16'(Y8), 16'd13);
        step(1'b1, 2'b11);
        check("walkD", 16'(Y8), 16'd1);

        // Mid-cycle data change has no effect until the next edge
        step(1'b1, 2'b00);
        #2;
        a8 = 8'd55;
        #1;
        check("midA", 16'(Y8), 16'd10);
        step(1'b1, 2'b00);
        check("newA", 16'(Y8), 16'd55);
        a8 = 8'd10;

        // Asynchronous reset between edges
        step(1'b1, 2'b10);
        check("preC", 16'(Y8), 16'd13);
        #2;
        rst_n = 1'b0;
        #1;
        check("async8", 16'(Y8), 16'd0);
        check("async16", Y16, 16'd0);
        check("async1", 16'(Y1), 16'd0);
        last = '0;
        step(1'b1, 2'b11);
        check("postD", 16'(Y8), 16'd1);

        // Random traffic with occasional reset
        for (int i = 0; i < 40; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom); d8 = 8'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom); c16 = 16'($urandom); d16 = 16'($urandom);
            a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom); d1 = 1'($urandom);
            step(($urandom_range(0, 9) != 0), 2'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
